pipeline_hazard_controller: RTL and testbench

Sequencing controller for the 3-stage pipeline register bank (execute, memory access, writeback).
- Tracks in-flight register destinations and detects read-after-write hazards against the instruction in decode.
- Holds decode during memory waits and SLP, and sequences flushes after branch mispredicts.
- Drives the stall vector and clear line consumed by the pipeline registers.

---
 rtl/pipeline_hazard_controller.sv | 199 +++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : RAW hazard tracking, memory/sleep holds and mispredict flush
//            sequencing for the 3-stage pipeline register bank.
// Revision : 1.0
// ============================================================================
module pipeline_hazard_controller #(
    parameter int NUM_REGS     = 8,
    parameter int STALL_BITS   = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                        clk,
    input  logic                        reset_gprc,
    input  logic                        dec_valid,
    input  logic [$clog2(NUM_REGS)-1:0] dec_src_a,
    input  logic [$clog2(NUM_REGS)-1:0] dec_src_b,
    input  logic                        dec_src_a_used,
    input  logic                        dec_src_b_used,
    input  logic [$clog2(NUM_REGS)-1:0] dec_dst,
    input  logic                        dec_writes,
    input  logic                        dec_slp,
    input  logic                        mem_req,
    input  logic                        mem_ready,
    input  logic                        branch_fail,
    input  logic                        wake,
    output logic [STALL_BITS-1:0]       stall_o,
    output logic                        clear_o,
    output logic [NUM_REGS-1:0]         busy_regs_o,
    output logic [1:0]                  state_o,
    output logic                        timeout_o
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam int MCNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [FCNT_W-1:0] C_FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES);
    localparam logic [MCNT_W-1:0] C_MEM_LAST   = MCNT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;
    localparam logic [1:0] ST_SLEEP    = 2'd3;

    logic [1:0]             r_state;
    logic [FCNT_W-1:0]      r_flush_cnt;
    logic [MCNT_W-1:0]      r_mem_cnt;
    logic                   r_pending;
    logic                   r_timeout;
    logic [2:0]             r_trk_valid;
    logic [2:0][IDX_W-1:0]  r_trk_dst;

    logic [1:0]             w_state_nxt;
    logic [FCNT_W-1:0]      w_flush_cnt_nxt;
    logic [MCNT_W-1:0]      w_mem_cnt_nxt;
    logic                   w_pending_nxt;
    logic                   w_timeout_nxt;
    logic                   w_enter_flush;
    logic [2:0]             w_raw;
    logic                   w_stall_any;
    logic                   w_issue_wr;
    logic                   w_mem_last;
    logic                   w_mem_done;

    // Entry index 0/1/2 corresponds to execute/memory/writeback.
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < 3; i++) begin
            w_raw[i] = dec_valid && r_trk_valid[i] &&
                       ((dec_src_a_used && (dec_src_a == r_trk_dst[i])) ||
                        (dec_src_b_used && (dec_src_b == r_trk_dst[i])));
        end
    end

    always_comb begin
        stall_o    = '0;
        stall_o[0] = w_raw[0];
        stall_o[1] = w_raw[1];
        stall_o[2] = w_raw[2];
        stall_o[3] = (r_state == ST_MEM_WAIT);
        stall_o[4] = (r_state == ST_FLUSH);
        stall_o[5] = (r_state == ST_SLEEP);
    end

    always_comb begin
        busy_regs_o = '0;
        for (int i = 0; i < 3; i++) begin
            if (r_trk_valid[i]) begin
                busy_regs_o[r_trk_dst[i]] = 1'b1;
            end
        end
    end

    assign clear_o     = (r_flush_cnt != '0);
    assign state_o     = r_state;
    assign timeout_o   = r_timeout;
    assign w_stall_any = |stall_o;
    assign w_issue_wr  = dec_valid && dec_writes && !w_stall_any && !clear_o;
    assign w_mem_last  = (r_mem_cnt == C_MEM_LAST);
    assign w_mem_done  = mem_ready || w_mem_last;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_mem_cnt_nxt   = r_mem_cnt;
        w_pending_nxt   = r_pending;
        w_timeout_nxt   = r_timeout;
        w_enter_flush   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (branch_fail) begin
                    w_enter_flush = 1'b1;
                end else if (mem_req && !mem_ready) begin
                    w_state_nxt   = ST_MEM_WAIT;
                    w_mem_cnt_nxt = '0;
                end else if (dec_valid && dec_slp && (w_raw == '0)) begin
                    w_state_nxt = ST_SLEEP;
                end
            end
            ST_MEM_WAIT: begin
                if (w_mem_done) begin
                    // A timeout releases the wait exactly like a completed access.
                    if (!mem_ready) begin
                        w_timeout_nxt = 1'b1;
                    end
                    if (r_pending || branch_fail) begin
                        w_enter_flush = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                    w_pending_nxt = 1'b0;
                end else begin
                    w_mem_cnt_nxt = r_mem_cnt + 1'b1;
                    w_pending_nxt = r_pending || branch_fail;
                end
            end
            ST_FLUSH: begin
                if (branch_fail) begin
                    w_flush_cnt_nxt = C_FLUSH_LOAD;
                end else if (r_flush_cnt <= FCNT_W'(1)) begin
                    w_state_nxt     = ST_RUN;
                    w_flush_cnt_nxt = '0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 1'b1;
                end
            end
            ST_SLEEP: begin
                if (branch_fail) begin
                    w_enter_flush = 1'b1;
                end else if (wake) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
        if (w_enter_flush) begin
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = C_FLUSH_LOAD;
        end
    end

    always_ff @(posedge clk or posedge reset_gprc) begin
        if (reset_gprc) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
            r_mem_cnt   <= '0;
            r_pending   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_mem_cnt   <= w_mem_cnt_nxt;
            r_pending   <= w_pending_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // The tracker shifts every cycle, stalled or not; a flush wipes all entries.
    always_ff @(posedge clk or posedge reset_gprc) begin
        if (reset_gprc) begin
            r_trk_valid <= '0;
            r_trk_dst   <= '0;
        end else begin
            r_trk_dst <= {r_trk_dst[1:0], dec_dst};
            if (w_enter_flush) begin
                r_trk_valid <= '0;
            end else begin
                r_trk_valid <= {r_trk_valid[1:0], w_issue_wr};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Purpose  : Scoreboard bench for pipeline_hazard_controller.
// Revision : 1.0
// ============================================================================
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       reset_gprc;
    logic       dec_valid, dec_src_a_used, dec_src_b_used, dec_writes, dec_slp;
    logic [2:0] dec_src_a, dec_src_b, dec_dst;
    logic       mem_req, mem_ready, branch_fail, wake;
    logic [7:0] stall_o;
    logic       clear_o;
    logic [7:0] busy_regs_o;
    logic [1:0] state_o;
    logic       timeout_o;

    always #5 clk = ~clk;

    pipeline_hazard_controller dut (
        .clk            (clk),
        .reset_gprc     (reset_gprc),
        .dec_valid      (dec_valid),
        .dec_src_a      (dec_src_a),
        .dec_src_b      (dec_src_b),
        .dec_src_a_used (dec_src_a_used),
        .dec_src_b_used (dec_src_b_used),
        .dec_dst        (dec_dst),
        .dec_writes     (dec_writes),
        .dec_slp        (dec_slp),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .branch_fail    (branch_fail),
        .wake           (wake),
        .stall_o        (stall_o),
        .clear_o        (clear_o),
        .busy_regs_o    (busy_regs_o),
        .state_o        (state_o),
        .timeout_o      (timeout_o)
    );

    typedef struct packed {
        logic       v;
        logic [2:0] sa;
        logic       sau;
        logic [2:0] sb;
        logic       sbu;
        logic [2:0] dst;
        logic       wr;
        logic       slp;
        logic       mreq;
        logic       mrdy;
        logic       bf;
        logic       wk;
    } stim_t;

    typedef struct {
        string       name;
        logic [19:0] val;
    } exp_t;

    stim_t       stq[$];
    logic [19:0] xq[$];
    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t ins(input int sa, input int sau, input int sb, input int sbu,
                                  input int dst, input int wr);
        stim_t s;
        s     = '0;
        s.v   = 1'b1;
        s.sa  = sa[2:0];
        s.sau = sau[0];
        s.sb  = sb[2:0];
        s.sbu = sbu[0];
        s.dst = dst[2:0];
        s.wr  = wr[0];
        return s;
    endfunction

    function automatic stim_t slp(input int sa, input int sau);
        stim_t s;
        s     = ins(sa, sau, 0, 0, 0, 0);
        s.slp = 1'b1;
        return s;
    endfunction

    function automatic stim_t ctl(input int mreq, input int mrdy, input int bf, input int wk);
        stim_t s;
        s      = '0;
        s.mreq = mreq[0];
        s.mrdy = mrdy[0];
        s.bf   = bf[0];
        s.wk   = wk[0];
        return s;
    endfunction

    // Expected output bundle: {stall, clear, busy, state, timeout}
    function automatic logic [19:0] ex(input int st, input int clr, input int busy,
                                       input int state, input int to);
        return {st[7:0], clr[0], busy[7:0], state[1:0], to[0]};
    endfunction

    task automatic apply(input stim_t s);
        dec_valid      = s.v;
        dec_src_a      = s.sa;
        dec_src_a_used = s.sau;
        dec_src_b      = s.sb;
        dec_src_b_used = s.sbu;
        dec_dst        = s.dst;
        dec_writes     = s.wr;
        dec_slp        = s.slp;
        mem_req        = s.mreq;
        mem_ready      = s.mrdy;
        branch_fail    = s.bf;
        wake           = s.wk;
    endtask

    task automatic add(input stim_t s, input logic [19:0] x);
        stq.push_back(s);
        xq.push_back(x);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [19:0] got;
        reset_gprc = 1'b1;
        apply(nop());
        @(negedge clk);
        e.name = "reset_hold"; e.val = ex(0, 0, 0, 0, 0); sbq.push_back(e);
        e = sbq.pop_front();
        got = {stall_o, clear_o, busy_regs_o, state_o, timeout_o};
        checks++;
        if (got !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        apply(ctl(1, 0, 1, 0));
        @(negedge clk);
        e.name = "reset_dominates"; e.val = ex(0, 0, 0, 0, 0); sbq.push_back(e);
        e = sbq.pop_front();
        got = {stall_o, clear_o, busy_regs_o, state_o, timeout_o};
        checks++;
        if (got !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        apply(nop());
        reset_gprc = 1'b0;
        @(negedge clk);
        e.name = "reset_release"; e.val = ex(0, 0, 0, 0, 0); sbq.push_back(e);
        e = sbq.pop_front();
        got = {stall_o, clear_o, busy_regs_o, state_o, timeout_o};
        checks++;
        if (got !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        @(negedge clk);
    endtask

    task automatic test_raw();
        exp_t e;
        logic [19:0] got;
        add(ins(0, 0, 0, 0, 3, 1), ex(8'h00, 0, 8'h00, 0, 0));
        for (int k = 0; k < 3; k++) add(ins(3, 1, 0, 0, 4, 1), ex(8'h01 << k, 0, 8'h08, 0, 0));
        add(ins(3, 1, 0, 0, 4, 1), ex(0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) add(nop(), ex(0, 0, 8'h10, 0, 0));
        add(nop(), ex(0, 0, 0, 0, 0));
        for (int i = 0; stq.size() > 0; i++) begin
            apply(stq.pop_front());
            e.name = $sformatf("raw[%0d]", i); e.val = xq.pop_front(); sbq.push_back(e);
            #2;
            e = sbq.pop_front();
            got = {stall_o, clear_o, busy_regs_o, state_o, timeout_o};
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [19:0] got;
        add(ins(4, 1, 0, 0, 1, 1), ex(0, 0, 0, 0, 0));
        add(ins(1, 0, 5, 1, 2, 1), ex(0, 0, 8'h02, 0, 0));
        add(nop(), ex(0, 0, 8'h06, 0, 0));
        add(ins(0, 0, 2, 1, 0, 0), ex(8'h02, 0, 8'h06, 0, 0));
        add(ins(0, 0, 2, 1, 0, 0), ex(8'h04, 0, 8'h04, 0, 0));
        add(ins(0, 0, 2, 1, 0, 0), ex(0, 0, 0, 0, 0));
        add(nop(), ex(0, 0, 0, 0, 0));
        for (int i = 0; stq.size() > 0; i++) begin
            apply(stq.pop_front());
            e.name = $sformatf("b2b[%0d]", i); e.val = xq.pop_front(); sbq.push_back(e);
            #2;
            e = sbq.pop_front();
            got = {stall_o, clear_o, busy_regs_o, state_o, timeout_o};
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mem_wait();
        exp_t e;
        logic [19:0] got;
        add(ctl(1, 1, 0, 0), ex(0, 0, 0, 0, 0));
        add(ctl(1, 0, 0, 0), ex(0, 0, 0, 0, 0));
        add(nop(), ex(8'h08, 0, 0, 1, 0));
        add(ins(0, 0, 0, 0, 6, 1), ex(8'h08, 0, 0, 1, 0));
        add(nop(), ex(8'h08, 0, 0, 1, 0));
        add(ctl(0, 1, 0, 0), ex(8'h08, 0, 0, 1, 0));
        add(nop(), ex(0, 0, 0, 0, 0));
        for (int i = 0; stq.size() > 0; i++) begin
            apply(stq.pop_front());
            e.name = $sformatf("mem[%0d]", i); e.val = xq.pop_front(); sbq.push_back(e);
            #2;
            e = sbq.pop_front();
            got = {stall_o, clear_o, busy_regs_o, state_o, timeout_o};
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        logic [19:0] got;
        add(ins(0, 0, 0, 0, 5, 1), ex(0, 0, 0, 0, 0));
        add(ctl(0, 0, 1, 0), ex(0, 0, 8'h20, 0, 0));
        add(ins(5, 1, 0, 0, 6, 1), ex(8'h10, 1, 0, 2, 0));
        add(ins(5, 1, 0, 0, 6, 1), ex(8'h10, 1, 0, 2, 0));
        add(ins(5, 1, 0, 0, 6, 1), ex(0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) add(nop(), ex(0, 0, 8'h40, 0, 0));
        add(nop(), ex(0, 0, 0, 0, 0));
        // A second mispredict while flushing restarts the clear window.
        add(ctl(0, 0, 1, 0), ex(0, 0, 0, 0, 0));
        add(nop(), ex(8'h10, 1, 0, 2, 0));
        add(ctl(0, 0, 1, 0), ex(8'h10, 1, 0, 2, 0));
        add(nop(), ex(8'h10, 1, 0, 2, 0));
        add(nop(), ex(8'h10, 1, 0, 2, 0));
        add(nop(), ex(0, 0, 0, 0, 0));
        for (int i = 0; stq.size() > 0; i++) begin
            apply(stq.pop_front());
            e.name = $sformatf("flush[%0d]", i); e.val = xq.pop_front(); sbq.push_back(e);
            #2;
            e = sbq.pop_front();
            got = {stall_o, clear_o, busy_regs_o, state_o, timeout_o};
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mem_flush();
        exp_t e;
        logic [19:0] got;
        add(ctl(1, 0, 0, 0), ex(0, 0, 0, 0, 0));
        add(ctl(0, 0, 1, 0), ex(8'h08, 0, 0, 1, 0));
        add(nop(), ex(8'h08, 0, 0, 1, 0));
        add(nop(), ex(8'h08, 0, 0, 1, 0));
        add(ctl(0, 1, 0, 0), ex(8'h08, 0, 0, 1, 0));
        add(nop(), ex(8'h10, 1, 0, 2, 0));
        add(nop(), ex(8'h10, 1, 0, 2, 0));
        add(nop(), ex(0, 0, 0, 0, 0));
        add(ctl(1, 0, 0, 0), ex(0, 0, 0, 0, 0));
        add(ctl(0, 1, 0, 0), ex(8'h08, 0, 0, 1, 0));
        add(nop(), ex(0, 0, 0, 0, 0));
        for (int i = 0; stq.size() > 0; i++) begin
            apply(stq.pop_front());
            e.name = $sformatf("memflush[%0d]", i); e.val = xq.pop_front(); sbq.push_back(e);
            #2;
            e = sbq.pop_front();
            got = {stall_o, clear_o, busy_regs_o, state_o, timeout_o};
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sleep();
        exp_t e;
        logic [19:0] got;
        add(slp(0, 0), ex(0, 0, 0, 0, 0));
        add(nop(), ex(8'h20, 0, 0, 3, 0));
        add(nop(), ex(8'h20, 0, 0, 3, 0));
        add(ctl(0, 0, 0, 1), ex(8'h20, 0, 0, 3, 0));
        add(nop(), ex(0, 0, 0, 0, 0));
        add(ins(0, 0, 0, 0, 2, 1), ex(0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) add(slp(2, 1), ex(8'h01 << k, 0, 8'h04, 0, 0));
        add(slp(2, 1), ex(0, 0, 0, 0, 0));
        add(ctl(0, 0, 1, 0), ex(8'h20, 0, 0, 3, 0));
        add(nop(), ex(8'h10, 1, 0, 2, 0));
        add(nop(), ex(8'h10, 1, 0, 2, 0));
        add(nop(), ex(0, 0, 0, 0, 0));
        for (int i = 0; stq.size() > 0; i++) begin
            apply(stq.pop_front());
            e.name = $sformatf("sleep[%0d]", i); e.val = xq.pop_front(); sbq.push_back(e);
            #2;
            e = sbq.pop_front();
            got = {stall_o, clear_o, busy_regs_o, state_o, timeout_o};
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        logic [19:0] got;
        add(ctl(1, 0, 0, 0), ex(0, 0, 0, 0, 0));
        for (int k = 0; k < 15; k++) add(nop(), ex(8'h08, 0, 0, 1, 0));
        add(nop(), ex(0, 0, 0, 0, 1));
        add(nop(), ex(0, 0, 0, 0, 1));
        for (int i = 0; stq.size() > 0; i++) begin
            apply(stq.pop_front());
            e.name = $sformatf("timeout[%0d]", i); e.val = xq.pop_front(); sbq.push_back(e);
            #2;
            e = sbq.pop_front();
            got = {stall_o, clear_o, busy_regs_o, state_o, timeout_o};
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_flush();
        exp_t e;
        logic [19:0] got;
        add(ctl(0, 0, 1, 0), ex(0, 0, 0, 0, 1));
        add(nop(), ex(8'h10, 1, 0, 2, 1));
        for (int i = 0; stq.size() > 0; i++) begin
            apply(stq.pop_front());
            e.name = $sformatf("midflush[%0d]", i); e.val = xq.pop_front(); sbq.push_back(e);
            #2;
            e = sbq.pop_front();
            got = {stall_o, clear_o, busy_regs_o, state_o, timeout_o};
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
            if (i == 0) @(negedge clk);
        end
        // Reset lands between clock edges; outputs must drop without a clock.
        reset_gprc = 1'b1;
        e.name = "async_reset"; e.val = ex(0, 0, 0, 0, 0); sbq.push_back(e);
        #1;
        e = sbq.pop_front();
        got = {stall_o, clear_o, busy_regs_o, state_o, timeout_o};
        checks++;
        if (got !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        @(negedge clk);
        reset_gprc = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_raw();
        test_back_to_back();
        test_mem_wait();
        test_flush();
        test_mem_flush();
        test_sleep();
        test_timeout();
        test_reset_mid_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
